// File: rtl/ss_wbm_arb.sv
// ---------------------------------------------------------------------------
// ss_wbm_arb : round-robin arbiter sharing one Wishbone master port between
// NREQ internal requesters (descriptor fetch, source read, destination write).
//
// A grant lasts for the requester's whole CYC, including CAB bursts, and is
// never preempted. A watchdog aborts a strobe that waits TIMEOUT cycles
// without ack/err/rty. It returns err to the requester and sets a sticky flag.
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   req_*_i                per-requester Wishbone master signals (slice i)
//   req_ack/err/rty_o      terminations routed to the granted requester only
//   req_dat_o              read data, wbm_dat_i passed through to everyone
//   wbm_*_o / wbm_*_i      shared external Wishbone master port
//   gnt_o                  one-hot current grant, 0 when idle
//   timeout_o, to_clr_i    sticky watchdog-fired flag and its clear
// ---------------------------------------------------------------------------
module ss_wbm_arb #(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 256,
   parameter int TW      = 9
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [NREQ-1:0]      req_cyc_i,
   input  logic [NREQ-1:0]      req_stb_i,
   input  logic [NREQ-1:0]      req_we_i,
   input  logic [NREQ-1:0]      req_cab_i,
   input  logic [32*NREQ-1:0]   req_adr_i,
   input  logic [32*NREQ-1:0]   req_dat_i,
   input  logic [4*NREQ-1:0]    req_sel_i,
   output logic [NREQ-1:0]      req_ack_o,
   output logic [NREQ-1:0]      req_err_o,
   output logic [NREQ-1:0]      req_rty_o,
   output logic [31:0]          req_dat_o,
   output logic                 wbm_cyc_o,
   output logic                 wbm_stb_o,
   output logic                 wbm_we_o,
   output logic                 wbm_cab_o,
   output logic [31:0]          wbm_adr_o,
   output logic [31:0]          wbm_dat_o,
   output logic [3:0]           wbm_sel_o,
   input  logic                 wbm_ack_i,
   input  logic                 wbm_err_i,
   input  logic                 wbm_rty_i,
   input  logic [31:0]          wbm_dat_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic                 timeout_o,
   input  logic                 to_clr_i
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_ABORT} state_e;

   state_e            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [LW-1:0]     last_q, last_d;   // also the index of the current grant
   logic [TW-1:0]     wd_q, wd_d;
   logic              timeout_q, timeout_d;

   logic [31:0]       adr_a [NREQ];
   logic [31:0]       dat_a [NREQ];
   logic [3:0]        sel_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign adr_a[i] = req_adr_i[32*i +: 32];
      assign dat_a[i] = req_dat_i[32*i +: 32];
      assign sel_a[i] = req_sel_i[4*i +: 4];
   end

   logic term;
   assign term = wbm_ack_i | wbm_err_i | wbm_rty_i;

   // Round-robin search starting just after the last granted requester.
   logic              pick_vld;
   logic [LW-1:0]     pick_idx;
   logic [LW:0]       sum;
   logic [LW-1:0]     idx;

   always_comb begin
      pick_vld = 1'b0;
      pick_idx = last_q;
      sum      = '0;
      idx      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         sum = {1'b0, last_q} + (LW+1)'(k);
         if (sum >= (LW+1)'(NREQ)) begin
            sum = sum - (LW+1)'(NREQ);
         end
         idx = sum[LW-1:0];
         if (!pick_vld && req_cyc_i[idx]) begin
            pick_vld = 1'b1;
            pick_idx = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      wd_d      = '0;
      timeout_d = timeout_q;
      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      wbm_we_o  = 1'b0;
      wbm_cab_o = 1'b0;
      wbm_adr_o = '0;
      wbm_dat_o = '0;
      wbm_sel_o = '0;
      req_ack_o = '0;
      req_err_o = '0;
      req_rty_o = '0;

      // Clear first so that a timeout in the same cycle overrides it.
      if (to_clr_i) begin
         timeout_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               gnt_d   = NREQ'(1) << pick_idx;
               last_d  = pick_idx;
               state_d = S_BUS;
            end
         end
         S_BUS: begin
            // CYC follows the requester so the bus drops in the same cycle.
            wbm_cyc_o = req_cyc_i[last_q];
            wbm_stb_o = req_stb_i[last_q];
            wbm_we_o  = req_we_i[last_q];
            wbm_cab_o = req_cab_i[last_q];
            wbm_adr_o = adr_a[last_q];
            wbm_dat_o = dat_a[last_q];
            wbm_sel_o = sel_a[last_q];
            req_ack_o[last_q] = wbm_ack_i;
            req_err_o[last_q] = wbm_err_i;
            req_rty_o[last_q] = wbm_rty_i;
            if (!req_cyc_i[last_q]) begin
               state_d = S_IDLE;
               gnt_d   = '0;
            end else if (req_stb_i[last_q] && !term) begin
               // A real termination in the last allowed cycle wins.
               if (wd_q == TW'(TIMEOUT-1)) begin
                  req_err_o[last_q] = 1'b1;
                  timeout_d         = 1'b1;
                  state_d           = S_ABORT;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
         end
         S_ABORT: begin
            if (!req_cyc_i[last_q]) begin
               state_d = S_IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         last_q    <= LW'(NREQ-1);
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign timeout_o = timeout_q;
   assign req_dat_o = wbm_dat_i;

endmodule

// File: tb/tb_ss_wbm_arb.sv
// Testbench for ss_wbm_arb: cycle-by-cycle vector table with a scoreboard
// queue, plus a short hand-written data-path sequence.
module tb_ss_wbm_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  cyc, stb, we, cab;
   logic [95:0] adr, dat;
   logic [11:0] sel;
   logic        ack, err, rty, clr;
   logic [31:0] wdat_i;

   logic [2:0]  req_ack_o, req_err_o, req_rty_o, gnt_o;
   logic [31:0] req_dat_o, wbm_adr_o, wbm_dat_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, timeout_o;
   logic [3:0]  wbm_sel_o;

   always #5 clk = ~clk;

   ss_wbm_arb #(.NREQ(3), .TIMEOUT(16), .TW(5)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .req_cyc_i(cyc), .req_stb_i(stb), .req_we_i(we), .req_cab_i(cab),
      .req_adr_i(adr), .req_dat_i(dat), .req_sel_i(sel),
      .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_rty_o(req_rty_o),
      .req_dat_o(req_dat_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_cab_o(wbm_cab_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_sel_o(wbm_sel_o),
      .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty), .wbm_dat_i(wdat_i),
      .gnt_o(gnt_o), .timeout_o(timeout_o), .to_clr_i(clr)
   );

   typedef struct {
      logic       rst;
      logic [2:0] cyc, stb, we, cab;
      logic       ack, err, rty, clr;
      logic [2:0] gnt;
      logic       bcyc, bstb, bwe, bcab;
      logic [2:0] ack_o, err_o, rty_o;
      logic       tmo;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   vec_t cur;
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [31:0] addr_of(input logic [2:0] g);
      case (g)
         3'b001:  return 32'h0000_0800;
         3'b010:  return 32'h0000_1000;
         3'b100:  return 32'h0000_2000;
         default: return 32'h0;
      endcase
   endfunction

   task automatic vin(input logic [2:0] c, input logic [2:0] s,
                      input logic a = 0, input logic e = 0, input logic r = 0,
                      input logic [2:0] w = 0, input logic [2:0] cb = 0,
                      input logic cl = 0, input logic rs = 0);
      cur.cyc = c; cur.stb = s; cur.ack = a; cur.err = e; cur.rty = r;
      cur.we = w; cur.cab = cb; cur.clr = cl; cur.rst = rs;
   endtask

   task automatic vexp(input logic [2:0] g, input logic bc, input logic bs,
                       input logic [2:0] ao = 0, input logic [2:0] eo = 0,
                       input logic [2:0] ro = 0, input logic t = 0,
                       input logic bw = 0, input logic bcb = 0);
      cur.gnt = g; cur.bcyc = bc; cur.bstb = bs; cur.ack_o = ao;
      cur.err_o = eo; cur.rty_o = ro; cur.tmo = t; cur.bwe = bw; cur.bcab = bcb;
      tbl.push_back(cur);
   endtask

   task automatic check_vec(input int i, input vec_t e);
      bit ok;
      ok = (gnt_o === e.gnt) && (wbm_cyc_o === e.bcyc) && (wbm_stb_o === e.bstb) &&
           (req_ack_o === e.ack_o) && (req_err_o === e.err_o) &&
           (req_rty_o === e.rty_o) && (timeout_o === e.tmo);
      if (e.gnt == 3'b000)
         ok = ok && (wbm_adr_o === 32'h0) && (wbm_we_o === 1'b0) && (wbm_cab_o === 1'b0) &&
              (wbm_dat_o === 32'h0) && (wbm_sel_o === 4'h0);
      else if (e.bcyc)
         ok = ok && (wbm_adr_o === addr_of(e.gnt)) && (wbm_we_o === e.bwe) &&
              (wbm_cab_o === e.bcab);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL vec%0d (actual/required): gnt=%b/%b cyc=%b/%b stb=%b/%b we=%b/%b cab=%b/%b adr=%h/%h ack=%b/%b err=%b/%b rty=%b/%b tmo=%b/%b",
                  i, gnt_o, e.gnt, wbm_cyc_o, e.bcyc, wbm_stb_o, e.bstb, wbm_we_o, e.bwe,
                  wbm_cab_o, e.bcab, wbm_adr_o, addr_of(e.gnt), req_ack_o, e.ack_o,
                  req_err_o, e.err_o, req_rty_o, e.rty_o, timeout_o, e.tmo);
      end
   endtask

   task automatic hchk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t e;
      int   waited;
      logic [2:0] oh, rest;

      adr = {32'h0000_2000, 32'h0000_1000, 32'h0000_0800};
      dat = {32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
      sel = {4'hF, 4'h3, 4'h1};
      rst = 1'b1; cyc = '0; stb = '0; we = '0; cab = '0;
      ack = 1'b0; err = 1'b0; rty = 1'b0; clr = 1'b0; wdat_i = '0;

      // Reset, then single read by requester 1 with retry and ack.
      vin(0,0,0,0,0,0,0,0,1); vexp(0,0,0);
      vin(2,2);               vexp(0,0,0);
      vin(2,2);               vexp(2,1,1);
      vin(2,2,0,0,1);         vexp(2,1,1,0,0,2);
      vin(2,2,1);             vexp(2,1,1,2);
      vin(0,0);               vexp(2,0,0);
      vin(0,0);               vexp(0,0,0);

      // Round robin 0,1,2,0,1,2 with all three requesting.
      vin(0,0,0,0,0,0,0,0,1); vexp(0,0,0);
      vin(7,7);               vexp(0,0,0);
      for (int k = 0; k < 6; k++) begin
         oh   = 3'b001 << (k % 3);
         rest = 3'b111 & ~oh;
         vin(7,7,1);          vexp(oh,1,1,oh);
         if (k < 5) begin
            vin(rest,rest);   vexp(oh,0,0);
            vin(7,7);         vexp(0,0,0);
         end else begin
            vin(0,0);         vexp(oh,0,0);
            vin(0,0);         vexp(0,0,0);
         end
      end

      // 8-beat CAB write burst by requester 2 while requester 0 waits.
      vin(4,4,0,0,0,4,4);     vexp(0,0,0);
      vin(5,5,0,0,0,4,4);     vexp(4,1,1,0,0,0,0,1,1);
      for (int k = 0; k < 8; k++) begin
         vin(5,5,1,0,0,4,4);  vexp(4,1,1,4,0,0,0,1,1);
      end
      vin(1,1);               vexp(4,0,0);
      vin(1,1);               vexp(0,0,0);
      vin(1,1,1);             vexp(1,1,1,1);
      vin(0,0);               vexp(1,0,0);
      vin(0,0);               vexp(0,0,0);

      // Bus error to requester 1, then ack exactly at count TIMEOUT-1.
      vin(2,2);               vexp(0,0,0);
      vin(2,2,0,1);           vexp(2,1,1,0,2);
      for (int k = 0; k < 15; k++) begin
         vin(2,2);            vexp(2,1,1);
      end
      vin(2,2,1);             vexp(2,1,1,2);
      vin(0,0);               vexp(2,0,0);
      vin(0,0);               vexp(0,0,0);

      // Watchdog: requester 0 strobes, bus never answers.
      vin(1,1);               vexp(0,0,0);
      for (int k = 0; k < 15; k++) begin
         vin(1,1);            vexp(1,1,1);
      end
      vin(1,1);               vexp(1,1,1,0,1);
      vin(1,1,1);             vexp(1,0,0,0,0,0,1);
      vin(0,0);               vexp(1,0,0,0,0,0,1);
      vin(0,0,0,0,0,0,0,1);   vexp(0,0,0,0,0,0,1);
      vin(0,0);               vexp(0,0,0);

      // Second timeout with to_clr_i in the same cycle: set wins.
      vin(1,1);               vexp(0,0,0);
      for (int k = 0; k < 15; k++) begin
         vin(1,1);            vexp(1,1,1);
      end
      vin(1,1,0,0,0,0,0,1);   vexp(1,1,1,0,1);
      vin(0,0);               vexp(1,0,0,0,0,0,1);
      vin(0,0);               vexp(0,0,0,0,0,0,1);

      // Reset in the middle of a burst by requester 1.
      vin(2,2,0,0,0,0,2);     vexp(0,0,0,0,0,0,1);
      vin(2,2,1,0,0,0,2);     vexp(2,1,1,2,0,0,1,0,1);
      vin(2,2,1,0,0,0,2,0,1); vexp(2,1,1,2,0,0,1,0,1);
      vin(7,7);               vexp(0,0,0);
      vin(7,7,1);             vexp(1,1,1,1);
      vin(6,6);               vexp(1,0,0);
      vin(0,0);               vexp(0,0,0);

      foreach (tbl[i]) begin
         rst = tbl[i].rst; cyc = tbl[i].cyc; stb = tbl[i].stb; we = tbl[i].we;
         cab = tbl[i].cab; ack = tbl[i].ack; err = tbl[i].err; rty = tbl[i].rty;
         clr = tbl[i].clr;
         exp_q.push_back(tbl[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         check_vec(i, e);
         @(posedge clk); #1;
      end

      // Data path: write by requester 2, read-data passthrough.
      rst = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0; clr = 1'b0;
      cyc = 3'b100; stb = 3'b100; we = 3'b100; cab = 3'b000;
      wdat_i = $urandom;
      waited = 0;
      @(negedge clk);
      while (gnt_o !== 3'b100 && waited < 5) begin
         @(negedge clk);
         waited++;
      end
      hchk("grant_wait", {29'b0, gnt_o}, 32'h4);
      hchk("wbm_dat", wbm_dat_o, 32'hD2D2_0002);
      hchk("wbm_sel", {28'b0, wbm_sel_o}, 32'hF);
      hchk("wbm_we", {31'b0, wbm_we_o}, 32'h1);
      hchk("req_dat_bus", req_dat_o, wdat_i);
      @(posedge clk); #1;
      cyc = '0; stb = '0; we = '0;
      @(posedge clk); #1;
      wdat_i = $urandom;
      @(negedge clk);
      hchk("wbm_dat_idle", wbm_dat_o, 32'h0);
      hchk("req_dat_idle", req_dat_o, wdat_i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
